// File: rtl/bake_countdown.sv
// bake_countdown: oven sequencer with preheat ramp, BCD MM:SS countdown and 4-digit display; define PAUSE_EN to honour pause_n
module bake_countdown #(
  parameter int AMBIENT = 70,
  parameter int STEP = 25,
  parameter int BLANK = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] load_temp,
  input  logic [9:0] load_min,
  input  logic       pause_n,
  input  logic       disp_sel,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       ready_led,
  output logic       done,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE, PREHEAT, COOK, DONE} mode_t;
`ifdef PAUSE_EN
  localparam logic pause_on = 1'b1;
`else
  localparam logic pause_on = 1'b0;
`endif
  localparam logic [3:0] blk = 4'(BLANK);
  mode_t st, nxt;
  logic [9:0] cur, tgt, n_cur, n_tgt, lt, lm;
  logic [3:0] m1, m0, s1, s0, n_m1, n_m0, n_s1, n_s0;
  logic [10:0] sum;
  logic tk, ld, zero;
  always_comb begin
    tk = tick & (pause_n | ~pause_on);
    ld = start & en & (st == IDLE | st == DONE);
    lt = load_temp > 10'd999 ? 10'd999 : load_temp;
    lm = load_min > 10'd99 ? 10'd99 : load_min;
    sum = {1'b0, cur} + 11'(STEP);
    zero = {m1, m0, s1, s0} == 16'd0;
    nxt = st;
    n_cur = cur;
    n_tgt = tgt;
    n_m1 = m1;
    n_m0 = m0;
    n_s1 = s1;
    n_s0 = s0;
    if (!en) begin
      nxt = IDLE;
      n_cur = '0;
      n_tgt = '0;
      n_m1 = '0;
      n_m0 = '0;
      n_s1 = '0;
      n_s0 = '0;
    end else if (ld) begin
      nxt = PREHEAT;
      n_tgt = lt;
      n_cur = 10'(AMBIENT) < lt ? 10'(AMBIENT) : lt;
      n_m1 = 4'(lm / 10'd10);
      n_m0 = 4'(lm % 10'd10);
      n_s1 = '0;
      n_s0 = '0;
    end else if (st == PREHEAT) begin
      nxt = cur == tgt ? COOK : PREHEAT;
      n_cur = !tk ? cur : sum > {1'b0, tgt} ? tgt : sum[9:0];
    end else if (st == COOK) begin
      nxt = zero ? DONE : COOK;
      if (tk & ~zero) begin
        n_s0 = s0 == 4'd0 ? 4'd9 : s0 - 4'd1;
        n_s1 = s0 != 4'd0 ? s1 : s1 == 4'd0 ? 4'd5 : s1 - 4'd1;
        n_m0 = (s1 | s0) != 4'd0 ? m0 : m0 == 4'd0 ? 4'd9 : m0 - 4'd1;
        n_m1 = (s1 | s0 | m0) != 4'd0 ? m1 : m1 - 4'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cur <= '0;
      tgt <= '0;
      m1 <= '0;
      m0 <= '0;
      s1 <= '0;
      s0 <= '0;
      digit3 <= blk;
      digit2 <= blk;
      digit1 <= blk;
      digit0 <= blk;
      ready_led <= 1'b0;
      done <= 1'b0;
      state <= '0;
    end else begin
      st <= nxt;
      cur <= n_cur;
      tgt <= n_tgt;
      m1 <= n_m1;
      m0 <= n_m0;
      s1 <= n_s1;
      s0 <= n_s0;
      digit3 <= st == IDLE ? blk : st == DONE ? 4'd0 : disp_sel ? blk : m1;
      digit2 <= st == IDLE ? blk : st == DONE ? 4'd0 : disp_sel ? 4'(cur / 10'd100) : m0;
      digit1 <= st == IDLE ? blk : st == DONE ? 4'd0 : disp_sel ? 4'((cur / 10'd10) % 10'd10) : s1;
      digit0 <= st == IDLE ? blk : st == DONE ? 4'd0 : disp_sel ? 4'(cur % 10'd10) : s0;
      ready_led <= st == COOK;
      done <= st == COOK && nxt == DONE;
      state <= st;
    end
  end
endmodule

// File: tb/tb_bake_countdown.sv
// tb_bake_countdown: randomized and directed stimulus against a seconds-based oven model with a queue scoreboard
module tb_bake_countdown;
  localparam int AMB = 70;
  localparam int STP = 25;
  localparam int BLK = 11;
`ifdef PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, tick = 1'b0, start = 1'b0, pause_n = 1'b1, disp_sel = 1'b0;
  logic [9:0] load_temp = '0, load_min = '0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic ready_led, done;
  logic [1:0] state;
  typedef struct packed {
    logic [3:0] d3, d2, d1, d0;
    logic rl, dn;
    logic [1:0] st;
  } obs_t;
  obs_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int m_mode = 0, m_temp = 0, m_tgt = 0, m_secs = 0;
  bake_countdown dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .start(start),
    .load_temp(load_temp), .load_min(load_min), .pause_n(pause_n), .disp_sel(disp_sel),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .ready_led(ready_led), .done(done), .state(state)
  );
  always #5 clk = ~clk;
  function automatic int min2(int a, int b);
    return a < b ? a : b;
  endfunction
  task automatic apply();
    obs_t e;
    bit tk;
    e.st = 2'(m_mode);
    e.rl = m_mode == 2;
    e.dn = en && m_mode == 2 && m_secs == 0;
    if (m_mode == 0) {e.d3, e.d2, e.d1, e.d0} = {4{4'(BLK)}};
    else if (m_mode == 3) {e.d3, e.d2, e.d1, e.d0} = 16'h0;
    else if (disp_sel) {e.d3, e.d2, e.d1, e.d0} = {4'(BLK), 4'(m_temp / 100), 4'(m_temp / 10 % 10), 4'(m_temp % 10)};
    else {e.d3, e.d2, e.d1, e.d0} = {4'(m_secs / 600), 4'(m_secs / 60 % 10), 4'(m_secs % 60 / 10), 4'(m_secs % 10)};
    tk = tick && (pause_n || !PAUSE);
    if (rst) begin
      e = {{4{4'(BLK)}}, 1'b0, 1'b0, 2'd0};
      m_mode = 0; m_temp = 0; m_tgt = 0; m_secs = 0;
    end else if (!en) begin
      m_mode = 0; m_temp = 0; m_tgt = 0; m_secs = 0;
    end else if (start && (m_mode == 0 || m_mode == 3)) begin
      m_tgt = min2(int'(load_temp), 999);
      m_temp = min2(AMB, m_tgt);
      m_secs = min2(int'(load_min), 99) * 60;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_temp == m_tgt) m_mode = 2;
      else if (tk) m_temp = min2(m_temp + STP, m_tgt);
    end else if (m_mode == 2) begin
      if (m_secs == 0) m_mode = 3;
      else if (tk) m_secs--;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask
  task automatic go(int n, bit t);
    for (int i = 0; i < n; i++) begin
      tick = t && (i % 2 == 1);
      apply();
    end
    tick = 1'b0;
  endtask
  task automatic kick(int t, int m);
    load_temp = 10'(t);
    load_min = 10'(m);
    start = 1'b1;
    apply();
    start = 1'b0;
  endtask
  initial forever begin
    obs_t e, a;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {digit3, digit2, digit1, digit0, ready_led, done, state};
      vectors++;
      if (a !== e)
        begin
          miscompares++;
          $display("FAIL outputs @%0t: got d=%0d,%0d,%0d,%0d led=%0b done=%0b state=%0d, expected d=%0d,%0d,%0d,%0d led=%0b done=%0b state=%0d",
                   $time, a.d3, a.d2, a.d1, a.d0, a.rl, a.dn, a.st, e.d3, e.d2, e.d1, e.d0, e.rl, e.dn, e.st);
        end
    end
  end
  initial begin
    go(3, 0);
    rst = 1'b0; en = 1'b1;
    go(3, 0);
    kick(350, 1);
    go(30, 1);
    disp_sel = 1'b1;
    go(10, 1);
    disp_sel = 1'b0;
    go(120, 1);
    go(5, 0);
    kick(1000, 150);
    go(90, 1);
    disp_sel = 1'b1;
    go(4, 1);
    disp_sel = 1'b0;
    go(6, 1);
    en = 1'b0;
    go(2, 0);
    en = 1'b1;
    kick(50, 0);
    go(6, 0);
    kick(100, 1);
    go(66, 1);
    en = 1'b0;
    go(3, 0);
    en = 1'b1;
    go(2, 0);
    load_temp = 10'd200; load_min = 10'd2;
    start = 1'b1; tick = 1'b1;
    apply();
    start = 1'b0; tick = 1'b0;
    go(4, 1);
    kick(500, 3);
    go(2, 1);
    rst = 1'b1;
    go(2, 0);
    rst = 1'b0;
    go(2, 0);
    kick(60, 1);
    go(30, 1);
    pause_n = 1'b0;
    go(10, 1);
    pause_n = 1'b1;
    go(6, 1);
    en = 1'b0;
    go(1, 0);
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      en = $urandom_range(0, 149) != 0;
      start = $urandom_range(0, 39) == 0;
      tick = $urandom_range(0, 2) == 0;
      pause_n = $urandom_range(0, 3) != 0;
      disp_sel = $urandom_range(0, 1) == 1;
      load_temp = $urandom_range(0, 3) == 0 ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 200));
      load_min = $urandom_range(0, 9) == 0 ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 1));
      apply();
    end
    rst = 1'b0; start = 1'b0; tick = 1'b0;
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
